// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   NOP_INSTR     : word presented to decode when the fetch FIFO head is empty.
//   fetch_state_t : fetch FSM states (RUN issues requests, DRAIN discards stale responses).
//   fetch_entry_t : one prefetch FIFO entry {pc, instr}.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with clear, used both as the prefetch
// buffer and as the in-flight request PC queue.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop all entries (takes priority over push/pop)
//   push/push_data : write one entry (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   head_data  : current head entry (registered storage)
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (count_r != FULL_CNT);
    assign do_pop_s  = pop && (count_r != {CW{1'b0}});

    // Entry storage; cleared on reset so the empty head reads as all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Read/write pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the fetch PC, issues in-order
// requests to instruction memory, buffers returned words in a prefetch FIFO
// and presents the FIFO head to the decode pipeline register.
//   clk, rst          : clock, synchronous active-high reset
//   stalld            : decode holding; head is not popped
//   pcsrce, pctargete : redirect request and target from Execute
//   imem_req_*        : request handshake, imem_addr is the fetch PC
//   imem_rsp_*        : in-order responses
//   validd/instrd/pcd/pcplus4d : decode-facing head of the prefetch FIFO
// Optional build macro FETCH_PERF_EN adds perf_stall_cycles and perf_dropped
// saturating counters; without it the ports and counters do not exist.
// DATA_WIDTH must equal fetch_pkg::XLEN (32).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stalld,
    input  logic                  pcsrce,
    input  logic [DATA_WIDTH-1:0] pctargete,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  validd,
    output logic [DATA_WIDTH-1:0] instrd,
    output logic [DATA_WIDTH-1:0] pcd,
    output logic [DATA_WIDTH-1:0] pcplus4d
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_dropped
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]           DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(32'd4);

    fetch_state_t          state_r;
    fetch_state_t          state_nx_s;
    logic [DATA_WIDTH-1:0] pcf_r;
    logic [DATA_WIDTH-1:0] pcf_nx_s;
    logic [CW-1:0]         drop_cnt_r;
    logic [CW-1:0]         drop_nx_s;
    logic [CW-1:0]         occ_s;
    logic [CW-1:0]         out_s;
    logic [CW:0]           credit_s;
    logic                  pop_s;
    logic                  accept_s;
    logic                  keep_s;
    logic [DATA_WIDTH-1:0] rsp_pc_s;
    fetch_entry_t          push_entry_s;
    fetch_entry_t          head_entry_s;

    assign validd = (occ_s != {CW{1'b0}});
    assign pop_s  = validd && !stalld && !pcsrce;

    // A response is kept only when nothing stale is pending and no redirect
    // is flushing the buffer in the same cycle.
    assign keep_s = imem_rsp_valid && (drop_cnt_r == {CW{1'b0}}) && !pcsrce;

    // Credits: every buffered word plus every outstanding request owns a FIFO
    // slot. The head leaving this cycle frees its slot early, which is what
    // sustains one fetch per cycle with a two-entry buffer.
    assign credit_s = {1'b0, occ_s} + {1'b0, out_s} - (CW + 1)'(pop_s);

    assign imem_req_valid = !rst && (state_r == RUN) && !pcsrce && (credit_s < DEPTH_LIM);
    assign accept_s       = imem_req_valid && imem_req_ready;
    assign imem_addr      = pcf_r;

    assign push_entry_s.pc    = rsp_pc_s;
    assign push_entry_s.instr = imem_rsp_data;

    // In-flight PC queue: one entry per accepted request, retired by every
    // response (kept or discarded), so its occupancy is the outstanding count.
    fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_pcq (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (accept_s),
        .push_data (pcf_r),
        .pop       (imem_rsp_valid),
        .head_data (rsp_pc_s),
        .count     (out_s)
    );

    // Prefetch buffer feeding decode; a redirect flushes it.
    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (pcsrce),
        .push      (keep_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .count     (occ_s)
    );

    // Next fetch PC, drop counter and FSM state.
    always_comb begin
        state_nx_s = state_r;
        pcf_nx_s   = pcf_r;
        drop_nx_s  = drop_cnt_r;
        if (pcsrce) begin
            // Everything still in flight is stale, except a response that is
            // being thrown away right now.
            pcf_nx_s   = pctargete;
            drop_nx_s  = out_s - CW'(imem_rsp_valid);
            state_nx_s = (drop_nx_s != {CW{1'b0}}) ? DRAIN : RUN;
        end else begin
            if (accept_s) begin
                pcf_nx_s = pcf_r + PC_STEP;
            end else begin
                pcf_nx_s = pcf_r;
            end
            case (state_r)
                RUN: begin
                    state_nx_s = RUN;
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        drop_nx_s  = drop_cnt_r - CW'(1'b1);
                        state_nx_s = (drop_cnt_r == CW'(1'b1)) ? RUN : DRAIN;
                    end else begin
                        state_nx_s = DRAIN;
                    end
                end
                default: begin
                    state_nx_s = RUN;
                end
            endcase
        end
    end

    // FSM, fetch PC and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            pcf_r      <= RESET_PC;
            drop_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            pcf_r      <= pcf_nx_s;
            drop_cnt_r <= drop_nx_s;
        end
    end

    assign pcd      = head_entry_s.pc;
    assign instrd   = validd ? head_entry_s.instr : NOP_INSTR;
    assign pcplus4d = head_entry_s.pc + PC_STEP;

`ifdef FETCH_PERF_EN
    logic        discard_s;
    logic [31:0] perf_stall_r;
    logic [31:0] perf_drop_r;

    assign discard_s = imem_rsp_valid && !keep_s;

    // Saturating stall-cycle and discarded-response counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_r <= 32'd0;
            perf_drop_r  <= 32'd0;
        end else begin
            if (validd && stalld && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (discard_s && (perf_drop_r != 32'hFFFF_FFFF)) begin
                perf_drop_r <= perf_drop_r + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_dropped      = perf_drop_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit. A memory model
// answers requests in order with word = address ^ 32'hA5A5_0000; a
// reference model (queue of expected head PCs, epoch-tagged in-flight
// requests) predicts decode outputs and request-valid each cycle.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stalld;
    logic        pcsrce;
    logic [31:0] pctargete;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        validd;
    logic [31:0] instrd;
    logic [31:0] pcd;
    logic [31:0] pcplus4d;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stalld         (stalld),
        .pcsrce         (pcsrce),
        .pctargete      (pctargete),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .validd         (validd),
        .instrd         (instrd),
        .pcd            (pcd),
        .pcplus4d       (pcplus4d)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_dropped      (perf_dropped)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];    // accepted requests awaiting a response
    logic [31:0] headq[$];   // expected PCs buffered for decode
    int          epoch     = 0;
    int          cyc       = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    logic [31:0] next_addr = 32'h0;
    int          m_dropped = 0;
    int          m_stall   = 0;
    int          n_assert  = 0;
    int          n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: check registered outputs, drive memory response,
    // check request-valid, advance the clock and update the model.
    task automatic cycle();
        logic        exp_v;
        logic        pop_m;
        logic        exp_rv;
        logic        acc;
        logic        rsp;
        logic [31:0] acc_addr;
        int          stale;
        req_t        r;
        exp_v = (headq.size() != 0);
        check("validd", 32'(validd), 32'(exp_v));
        if (exp_v) begin
            check("pcd", pcd, headq[0]);
            check("instrd", instrd, headq[0] ^ KEY);
            check("pcplus4d", pcplus4d, headq[0] + 32'd4);
        end else begin
            check("instrd_nop", instrd, NOP);
        end
        check("imem_addr", imem_addr, next_addr);
`ifdef FETCH_PERF_EN
        check("perf_dropped", perf_dropped, 32'(m_dropped));
        check("perf_stall", perf_stall_cycles, 32'(m_stall));
`endif
        rsp = !rst && (memq.size() != 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? (memq[0].addr ^ KEY) : 32'hDEAD_BEEF;
        #1;
        stale = 0;
        foreach (memq[i]) if (memq[i].epoch != epoch) stale++;
        pop_m  = exp_v && !stalld && !pcsrce;
        exp_rv = !rst && !pcsrce && (stale == 0) &&
                 ((memq.size() + headq.size() - (pop_m ? 1 : 0)) < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            memq.delete();
            headq.delete();
            next_addr = 32'h0;
            m_dropped = 0;
            m_stall   = 0;
        end else begin
            if (exp_v && stalld) m_stall++;
            if (pop_m) void'(headq.pop_front());
            if (rsp) begin
                r = memq.pop_front();
                if ((r.epoch == epoch) && !pcsrce) headq.push_back(r.addr);
                else m_dropped++;
            end
            if (acc) begin
                memq.push_back('{acc_addr, epoch, cyc + $urandom_range(lat_max, lat_min)});
                next_addr = next_addr + 32'd4;
            end
            if (pcsrce) begin
                headq.delete();
                epoch++;
                next_addr = pctargete;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        stalld         = 1'b0;
        pcsrce         = 1'b0;
        imem_req_ready = 1'b1;
        memq.delete();
        repeat (2) cycle();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_reset_values();
        check("rst_validd", 32'(validd), 32'd0);
        check("rst_instrd", instrd, NOP);
        check("rst_pcd", pcd, 32'h0);
        check("rst_pcplus4d", pcplus4d, 32'h4);
        check("rst_imem_addr", imem_addr, 32'h0);
    endtask

    initial begin
        logic found;
        logic saw;
        rst            = 1'b1;
        stalld         = 1'b0;
        pcsrce         = 1'b0;
        pctargete      = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back fetch with a one-cycle memory.
        lat_min = 1; lat_max = 1;
        do_reset();
        check_reset_values();
        for (int k = 0; k < 20; k++) begin
            if (k >= 2) check("contiguous_validd", 32'(validd), 32'd1);
            cycle();
        end

        // Decode stall while the head is 0x8.
        do_reset();
        repeat (4) cycle();
        stalld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("stall_head_pc", pcd, 32'h8);
            check("stall_credit", 32'((memq.size() + headq.size()) <= DEPTH), 32'd1);
            cycle();
        end
        stalld = 1'b0;
        repeat (10) cycle();

        // Memory back-pressure on the request at 0xC.
        do_reset();
        repeat (3) cycle();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("held_addr", imem_addr, 32'hC);
            cycle();
        end
        imem_req_ready = 1'b1;
        cycle();
        check("held_accepted", memq.size() > 0 ? memq[memq.size()-1].addr : 32'hFFFF_FFFF, 32'hC);
        repeat (8) cycle();

        // Redirect to 0x100 with two requests in flight, 3-cycle memory.
        lat_min = 3; lat_max = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memq.size() == 2) found = 1'b1;
            else cycle();
        end
        check("wait_two_outstanding", 32'(found), 32'd1);
        pcsrce = 1'b1; pctargete = 32'h100;
        cycle();
        pcsrce = 1'b0;
        check("redirect_flush", 32'(validd), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (validd) found = 1'b1;
            else cycle();
        end
        check("redirect_target_arrives", 32'(found), 32'd1);
        check("redirect_first_pc", pcd, 32'h100);
`ifdef FETCH_PERF_EN
        check("redirect_perf_dropped", perf_dropped, 32'd2);
`endif

        // Back-to-back redirects while requests are in flight.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memq.size() != 0) found = 1'b1;
            else cycle();
        end
        check("wait_outstanding", 32'(found), 32'd1);
        pcsrce = 1'b1; pctargete = 32'h200;
        cycle();
        pctargete = 32'h300;
        cycle();
        pcsrce = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            check("no_stale_0x200", 32'(validd && (pcd == 32'h200)), 32'd0);
            if (validd && (pcd == 32'h300)) saw = 1'b1;
            cycle();
        end
        check("saw_0x300", 32'(saw), 32'd1);

        // Fetch PC wraps past 0xFFFF_FFFC.
        lat_min = 1; lat_max = 1;
        pcsrce = 1'b1; pctargete = 32'hFFFF_FFF8;
        cycle();
        pcsrce = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (validd && (pcd == 32'hFFFF_FFFC)) begin
                saw = 1'b1;
                check("wrap_pcplus4d", pcplus4d, 32'h0);
            end
            cycle();
        end
        check("saw_wrap_head", 32'(saw), 32'd1);

        // Randomized traffic: latency, back-pressure, stalls and redirects.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            stalld         = ($urandom_range(3, 0) == 0);
            imem_req_ready = ($urandom_range(3, 0) != 0);
            pcsrce         = ($urandom_range(19, 0) == 0);
            pctargete      = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'h0000_FFFC);
            cycle();
        end
        stalld = 1'b0; pcsrce = 1'b0; imem_req_ready = 1'b1;

        // Reset in the middle of traffic.
        do_reset();
        check_reset_values();
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core. It consumes the hazard unit's stall and redirect decisions, owns the PC register, and issues in-order requests to instruction memory through a valid/ready handshake. Fetched words go into a small prefetch FIFO, and the FIFO head is presented to the decode pipeline register. On a taken branch or jump it discards stale fetches and restarts at the target.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DATA_WIDTH, 32: instruction and address width.
- FIFO_DEPTH, 2: prefetch entries. Power of two, at least 2. Also the maximum number of outstanding requests.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stalld  in  1  decode register holding. Do not pop the FIFO head.
- pcsrce  in  1  redirect request from Execute.
- pctargete  in  DATA_WIDTH  redirect address.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  DATA_WIDTH  request address (the PC).
- imem_rsp_valid  in  1  response valid. Responses arrive in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  DATA_WIDTH  instruction word.
- validd  out  1  FIFO head holds a real instruction.
- instrd  out  DATA_WIDTH  head instruction. 32'h0000_0013 (NOP) when validd=0.
- pcd  out  DATA_WIDTH  head PC.
- pcplus4d  out  DATA_WIDTH  pcd + 4, modulo 2^32.

## Operation
- FSM states:
  - RUN: issue requests.
  - DRAIN: no requests; discard stale responses.
- Request issue:
  - Condition: imem_req_valid = (state==RUN) && !pcsrce && (occupancy + outstanding < FIFO_DEPTH).
  - On acceptance (valid && ready): outstanding += 1, pcf += 4.
  - pcf wraps modulo 2^32.
- A request held with valid=1 and ready=0 keeps imem_addr stable until accepted. The exception is pcsrce, which withdraws the request.
- Responses:
  - When imem_rsp_valid and drop_cnt == 0: push {pc, data} into the FIFO and decrement outstanding. The PC comes from an internal in-flight PC queue, or is recomputed from the head PC.
  - When drop_cnt > 0: decrement drop_cnt and outstanding; the FIFO is not written.
- Pop:
  - Condition: validd && !stalld && !pcsrce.
  - Push and pop in the same cycle: occupancy unchanged.
  - Full FIFO: no push occurs, because the credit rule guarantees room.
- Redirect (pcsrce=1):
  - pcf ← pctargete.
  - FIFO cleared, so validd=0 next cycle.
  - drop_cnt ← outstanding, minus any response discarded in the same cycle.
  - Next state is DRAIN if that count is nonzero, otherwise RUN.
  - pcsrce in DRAIN: reload pcf again and stay in DRAIN.
- DRAIN → RUN in the cycle after drop_cnt reaches 0.
- Reset mid-operation:
  - All state cleared, pcf=RESET_PC, state=RUN.
  - Responses to requests issued before reset are the memory's responsibility. The memory is reset on the same rst.

## Timing
- Reset values:
  - imem_req_valid=0 during rst; asserted the first cycle after rst falls.
  - imem_addr=RESET_PC.
  - validd=0, instrd=NOP, pcd=0, pcplus4d=4.
- Latency:
  - Response arriving in cycle N: validd=1 with that word in cycle N+1 (registered FIFO).
  - Zero-wait memory (1-cycle response): first validd 2 cycles after reset release.
- Throughput: one instruction per cycle with 1-cycle memory latency and FIFO_DEPTH ≥ 2.
- Redirect in cycle N: imem_addr=pctargete in N+1 if no requests are outstanding.
- Target instruction reaches the head by N+3 at the earliest.
- All outputs registered except imem_req_valid, which is combinational on pcsrce.

## Configuration
- FETCH_PERF_EN:
  - Defined: adds outputs perf_stall_cycles (32 bits) and perf_dropped (32 bits).
    - perf_stall_cycles counts cycles with validd && stalld.
    - perf_dropped counts discarded responses.
    - Both saturating; cleared by rst.
  - Undefined: ports and counters absent. Fetch behaviour is identical.

## Structure
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum {RUN, DRAIN}.
  - fetch_entry_t struct {pc, instr}.
- One sub-module: fetch_fifo (parameterised depth, push/pop/clear, occupancy output). The PC queue instantiates the same module.

## Test plan
- Reset, 1-cycle memory returning words equal to address ^ 32'hA5A5_0000 → addresses 0,4,8,… issued back-to-back; validd continuous from cycle 2; pcd/instrd pairs match.
- stalld held high 5 cycles with FIFO_DEPTH=2 → at most 2 outstanding-plus-buffered; imem_req_valid drops; head stays pcd=0x8. Release → pops resume with no lost or duplicated word.
- imem_req_ready=0 for 3 cycles → imem_addr stable at 0xC; accepted on the 4th cycle; order preserved.
- pcsrce=1 with pctargete=0x100 while 2 requests outstanding, 3-cycle memory latency:
  - state DRAIN; the next 2 responses are discarded and validd stays 0.
  - Next request address is 0x100; first valid pcd=0x100.
- Back-to-back pcsrce (targets 0x200, then 0x300) during DRAIN → only 0x300 fetched; no 0x200 word ever at the head.
- pcf=32'hFFFF_FFFC → next request address 0x0; pcplus4d for that head = 0x0.
- With FETCH_PERF_EN: the redirect scenario above leaves perf_dropped=2.
